// File: rtl/pool2_fmap_writer.sv
// Streaming 2x2 max-pool + ReLU over CHANNELS parallel maps. Pooled pixels go out
// on a shared-address, per-bank-data write port in raster order.
module pool2_fmap_writer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CHANNELS   = 16,
  parameter int unsigned IN_DIM     = 28
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic                           wr_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] wr_data,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned OUT_DIM = IN_DIM / 2;
  localparam int unsigned CNT_W   = $clog2(IN_DIM);
  localparam int unsigned BUS_W   = CHANNELS * DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic             wr_en_d, done_d, busy_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [BUS_W-1:0] wr_data_d;

  logic accept_c, last_col_c, last_row_c;

  // Per-channel pair register and half-width line buffer; written before read each frame
  logic signed [DATA_WIDTH-1:0] h_q  [CHANNELS];
  logic signed [DATA_WIDTH-1:0] lb_q [CHANNELS][OUT_DIM];

  logic signed [DATA_WIDTH-1:0] sample_c [CHANNELS];
  logic signed [DATA_WIDTH-1:0] hmax_c   [CHANNELS];
  logic signed [DATA_WIDTH-1:0] pool_c   [CHANNELS];

  assign accept_c   = (state_q == S_RUN) && in_valid;
  assign last_col_c = (col_q == CNT_W'(IN_DIM - 1));
  assign last_row_c = (row_q == CNT_W'(IN_DIM - 1));

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wr_en   <= wr_en_d;
      busy    <= busy_d;
      done    <= done_d;
      if (wr_en_d) begin
        wr_addr <= wr_addr_d;
        wr_data <= wr_data_d;
      end
    end
  end

  // Next-state, counter advance and write strobe
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          wr_en_d = row_q[0] & col_q[0];
          if (last_col_c) begin
            col_d = '0;
            row_d = row_q + CNT_W'(1);
          end else begin
            col_d = col_q + CNT_W'(1);
          end
          if (last_col_c && last_row_c) begin
            state_d = S_LAST;
            done_d  = 1'b1;
            row_d   = '0;
          end
        end
      end
      S_LAST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign wr_addr_d = ADDR_WIDTH'(32'(row_q >> 1) * OUT_DIM + 32'(col_q >> 1));

  // Horizontal max, vertical max against the line buffer, then ReLU
  always_comb begin
    wr_data_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sample_c[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      hmax_c[k]   = (h_q[k] > sample_c[k]) ? h_q[k] : sample_c[k];
      pool_c[k]   = (lb_q[k][col_q[CNT_W-1:1]] > hmax_c[k]) ? lb_q[k][col_q[CNT_W-1:1]] : hmax_c[k];
      wr_data_d[k*DATA_WIDTH +: DATA_WIDTH] = pool_c[k][DATA_WIDTH-1] ? '0 : pool_c[k];
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (!col_q[0]) begin
          h_q[k] <= sample_c[k];
        end else if (!row_q[0]) begin
          lb_q[k][col_q[CNT_W-1:1]] <= hmax_c[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2_fmap_writer.sv
// Directed bench for pool2_fmap_writer: reference max-pool model over a stored image,
// write-port monitor, and immediate assertions at each comparison.
module tb_pool2_fmap_writer;

  localparam int DW = 16;
  localparam int CH = 16;
  localparam int DIM = 28;
  localparam int OD = 14;
  localparam int DEPTH = 196;
  localparam int BW = CH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [BW-1:0] in_data;
  logic [7:0]    wr_addr;
  logic          wr_en;
  logic [BW-1:0] wr_data;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic signed [DW-1:0] img [CH][DIM][DIM];
  int comp_cyc [DEPTH];

  int            wq_addr [$];
  logic [BW-1:0] wq_data [$];
  int            wq_cyc  [$];
  bit            wq_done [$];

  pool2_fmap_writer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
      wq_done.push_back(done === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] chan(input logic [BW-1:0] w, input int k);
    return w[k*DW +: DW];
  endfunction

  function automatic logic [BW-1:0] pack_px(input int r, input int c);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = img[k][r][c];
    return v;
  endfunction

  // Reference: max of the four window pixels, clamped at zero
  function automatic logic [BW-1:0] exp_word(input int a);
    logic [BW-1:0] w;
    logic signed [DW-1:0] m;
    int r, c;
    r = (a / OD) * 2;
    c = (a % OD) * 2;
    w = '0;
    for (int k = 0; k < CH; k++) begin
      m = img[k][r][c];
      if (img[k][r][c+1] > m) m = img[k][r][c+1];
      if (img[k][r+1][c] > m) m = img[k][r+1][c];
      if (img[k][r+1][c+1] > m) m = img[k][r+1][c+1];
      if (m < 0) m = '0;
      w[k*DW +: DW] = m;
    end
    return w;
  endfunction

  task automatic fill_ramp();
    for (int k = 0; k < CH; k++)
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) img[k][r][c] = 16'(r * DIM + c + k);
  endtask

  task automatic set_win(input int k, input int wr, input int wc,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    img[k][2*wr][2*wc]     = a;
    img[k][2*wr][2*wc+1]   = b;
    img[k][2*wr+1][2*wc]   = c;
    img[k][2*wr+1][2*wc+1] = d;
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    wq_done.delete();
  endtask

  // Called and returns at a negedge; on return the final beat has just been sampled
  task automatic drive_frame(input int gap_max, input int nbeats, input bit poke);
    int r, c, g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      r = b / DIM;
      c = b % DIM;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = {8{$urandom()}};
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = pack_px(r, c);
      start    = poke && (b % 97 == 50);
      if ((r % 2 == 1) && (c % 2 == 1)) comp_cyc[(r / 2) * OD + c / 2] = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int n;
    check($sformatf("%s_count", tag), wq_addr.size(), DEPTH);
    n = (wq_addr.size() < DEPTH) ? wq_addr.size() : DEPTH;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wq_addr[i], i);
      check($sformatf("%s_data%0d", tag, i), wq_data[i], exp_word(i));
      check($sformatf("%s_done%0d", tag, i), 256'(wq_done[i]), 256'(i == DEPTH - 1));
      check($sformatf("%s_lat%0d", tag, i), wq_cyc[i], comp_cyc[i] + 1);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [BW-1:0] ch3_only;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    check_idle_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Ramp, back-to-back beats, start pulse during LAST ignored
    fill_ramp();
    clear_q();
    drive_frame(0, DIM * DIM, 1'b0);
    check("ramp_last_done", done, 1);
    check("ramp_last_busy", busy, 1);
    check("ramp_last_wr_en", wr_en, 1);
    check("ramp_last_addr", wr_addr, DEPTH - 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ramp_after_busy", busy, 0);
    check("ramp_after_done", done, 0);
    check("ramp_after_wr_en", wr_en, 0);
    @(negedge clk);
    check("ramp_late_start_busy", busy, 0);
    check_frame("ramp");
    check("ramp_a0_c0", chan(wq_data[0], 0), 16'd29);
    check("ramp_a0_c15", chan(wq_data[0], 15), 16'd44);
    check("ramp_a195_c0", chan(wq_data[195], 0), 16'd783);
    check("ramp_a195_c15", chan(wq_data[195], 15), 16'd798);

    // Sign handling and ReLU, with gaps and stray start pulses mid-frame
    for (int k = 0; k < CH; k++)
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) img[k][r][c] = 16'(k);
    set_win(0, 0, 0, -16'sd5, -16'sd3, -16'sd8, -16'sd1);
    set_win(1, 0, 0, -16'sd5, 16'sd7, 16'sd3, 16'sd2);
    set_win(2, 0, 0, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    set_win(3, 0, 0, 16'h7FFF, -16'sd1, 16'sd0, 16'sd5);
    set_win(0, 13, 13, -16'sd5, -16'sd3, -16'sd8, -16'sd1);
    set_win(5, 6, 7, 16'h8000, -16'sd2, 16'h7FFF, 16'h8001);
    clear_q();
    drive_frame(2, DIM * DIM, 1'b1);
    repeat (2) @(negedge clk);
    check_frame("relu");
    check("relu_neg", chan(wq_data[0], 0), 16'h0000);
    check("relu_mix", chan(wq_data[0], 1), 16'h0007);
    check("relu_min", chan(wq_data[0], 2), 16'h0000);
    check("relu_max", chan(wq_data[0], 3), 16'h7FFF);
    check("relu_plain", chan(wq_data[0], 4), 16'h0004);
    check("relu_last_neg", chan(wq_data[195], 0), 16'h0000);
    check("relu_mid", chan(wq_data[6 * OD + 7], 5), 16'h7FFF);

    // Channel independence
    for (int k = 0; k < CH; k++)
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) img[k][r][c] = (k == 3) ? 16'sd100 : 16'(-(k + 1));
    ch3_only = BW'(100) << 48;
    clear_q();
    drive_frame(0, DIM * DIM, 1'b0);
    repeat (2) @(negedge clk);
    check_frame("chan");
    check("chan_a0", wq_data[0], ch3_only);
    check("chan_a97", wq_data[97], ch3_only);
    check("chan_a195", wq_data[195], ch3_only);

    // Gapped ramp
    fill_ramp();
    clear_q();
    drive_frame(3, DIM * DIM, 1'b0);
    repeat (2) @(negedge clk);
    check_frame("gap");
    check("gap_a0_c0", chan(wq_data[0], 0), 16'd29);
    check("gap_a195_c7", chan(wq_data[195], 7), 16'd790);

    // Reset mid-frame, idle beats ignored, then a full frame
    clear_q();
    drive_frame(0, 400, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outs("midrst");
    clear_q();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = {8{$urandom()}};
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_beats_writes", wq_addr.size(), 0);
    check("idle_beats_busy", busy, 0);
    drive_frame(0, DIM * DIM, 1'b0);
    repeat (2) @(negedge clk);
    check_frame("rstframe");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool2_fmap_writer.md
# pool2_fmap_writer

Streaming 2x2 max-pool + ReLU stage that turns 16 parallel channels of 28x28 signed convolution results into 14x14 pooled maps. It drives the write side of the 16-bank feature-map buffer: one shared address, one shared write enable and one 16-bit word per bank, so that pooled pixel (r,c) of channel k lands at address r*14+c of bank k. Raster-order input with a valid strobe; a start/busy/done handshake frames each image.

## Interface
- DATA_WIDTH, 16, signed two's-complement sample width
- ADDR_WIDTH, 8, feature-map address width
- CHANNELS, 16, parallel channels (one per bank)
- IN_DIM, 28, input map side; must be even; OUT_DIM = IN_DIM/2, DEPTH = OUT_DIM^2 = 196

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a frame when idle
- in_valid  in  1  in_data carries one pixel (all channels) this cycle
- in_data  in  CHANNELS*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- wr_addr  out  ADDR_WIDTH  shared write address for all banks
- wr_en  out  1  shared write enable for all banks
- wr_data  out  CHANNELS*DATA_WIDTH  channel k pooled value, same packing as in_data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse with final write of a frame

## Operation
- FSM states: IDLE, RUN, LAST.
  - IDLE: in_valid ignored; start -> RUN, row/col counters cleared.
  - RUN: each in_valid beat accepted; col increments 0..IN_DIM-1, wraps to 0 with row increment. Beat at (IN_DIM-1, IN_DIM-1) -> LAST.
  - LAST: one cycle; final write issued, done=1 -> IDLE.
- start in RUN or LAST ignored.
- Per channel, independent:
  - even col: register sample in pair register h.
  - odd col: hmax = signed max(h, sample).
  - even row, odd col: line buffer[col>>1] <= hmax (OUT_DIM entries per channel).
  - odd row, odd col: p = signed max(line buffer[col>>1], hmax); out = (p < 0) ? 0 : p; write at addr (row>>1)*OUT_DIM + (col>>1).
- All compares signed; no width growth, no saturation; 0x8000 valid input (yields 0 after ReLU).
- Writes strictly in address order 0..DEPTH-1, exactly DEPTH writes per frame.
- Idle gaps in in_valid allowed anywhere; state and buffers hold.

## Timing
- Reset: state IDLE, counters 0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. Line buffer/pair registers not reset (always written before read).
- Output registers: beat accepted at cycle T completing a window -> wr_en=1 with wr_addr/wr_data at T+1; wr_en=0 otherwise. wr_addr/wr_data hold last value when wr_en=0.
- Final beat at T: state LAST at T+1 with wr_en=1, wr_addr=DEPTH-1, done=1; busy=0 and state IDLE at T+2.
- busy=1 from cycle after accepted start through LAST inclusive.
- Back-to-back: start at T+1 (during LAST) ignored; start accepted from T+2.
- rst mid-frame: next cycle all outputs at reset values, pending write dropped; new frame requires start.
- Throughput: one beat per cycle sustained; no backpressure (no ready).

## Test plan
- Ramp: start, 784 back-to-back beats, channel k value = row*28+col+k -> 196 writes, addr 0 data 29+k, addr 195 data 783+k, done with last write, busy low next cycle.
- Sign/ReLU: window {-5,-3,-8,-1} -> 0; {-5,7,3,2} -> 7; all 0x8000 -> 0; {0x7FFF,-1,0,5} -> 0x7FFF.
- Channel independence: channel k all -(k+1), except channel 3 all 100 -> channel 3 words 100, others 0, every address.
- Gapped valid: random 0-3 idle cycles between beats -> identical write sequence to ramp test, each wr_en exactly one cycle after the completing beat.
- Reset mid-frame after 400 beats, then start and full ramp -> no write before new start, busy=0 during idle, 196 correct writes.
- Protocol: in_valid beats while IDLE and start pulses during RUN/LAST -> no effect; beats before start not counted.
